// File: rtl/motion_object_line_fetch_if.sv
// motion_object_line_fetch_if: object RAM / graphics ROM fetch, line-buffer write and control signals
//   master: the line-fetch block (drives addresses, write stream, busy/overflow)
//   slave : the surrounding video system (drives ce, line_start, vline, memory data)
interface motion_object_line_fetch_if;
   logic        ce;
   logic        line_start;
   logic [7:0]  vline;
   logic [7:0]  mo_addr;
   logic [7:0]  mo_data;
   logic [13:0] gfx_addr;
   logic [7:0]  gfx_data;
   logic [7:0]  buf_addr;
   logic [2:0]  buf_ar;
   logic        buf_api;
   logic        buf_we;
   logic        busy;
   logic        overflow;
   modport master(
      input  ce, line_start, vline, mo_data, gfx_data,
      output mo_addr, gfx_addr, buf_addr, buf_ar, buf_api, buf_we, busy, overflow
   );
   modport slave(
      output ce, line_start, vline, mo_data, gfx_data,
      input  mo_addr, gfx_addr, buf_addr, buf_ar, buf_api, buf_we, busy, overflow
   );
endinterface

// File: rtl/motion_object_line_fetch.sv
// motion_object_line_fetch: scans object RAM for objects on the next scanline and streams their opaque pixels to the line buffer
//   clk, reset   clock, synchronous active-high reset
//   bus          ce/line_start/vline control, object RAM and graphics ROM fetch (1 ce cycle read latency),
//                line-buffer write stream (buf_addr/buf_ar/buf_api/buf_we), busy and overflow status
//   MO_HFLIP_EN  when defined, attr bit 6 mirrors the object horizontally
module motion_object_line_fetch #(
   parameter int NUM_OBJ      = 32,
   parameter int MAX_PER_LINE = 8,
   parameter int OBJ_H        = 16
) (
   input logic                        clk,
   input logic                        reset,
   motion_object_line_fetch_if.master bus
);
   localparam int OW = $clog2(NUM_OBJ);
   localparam int DW = $clog2(MAX_PER_LINE + 1);
   typedef enum logic [2:0] {IDLE, SCAN, ATTR, GFX, DRAW, DONE} state_t;
   state_t        state;
   logic [OW-1:0] obj;
   logic [DW-1:0] drawn;
   logic [2:0]    step;
   logic [3:0]    row;
   logic [7:0]    code, x, p0, p1, p2;
   logic          api;
   logic [7:0]    diff;
   logic [2:0]    bit_sel;
   logic [2:0]    pix;
   logic          last_obj;
   assign diff     = bus.vline - bus.mo_data;
   assign last_obj = obj == OW'(NUM_OBJ - 1);
`ifdef MO_HFLIP_EN
   logic hflip;
   assign bit_sel = hflip ? step : 3'd7 - step;
`else
   assign bit_sel = 3'd7 - step;
`endif
   assign pix = {p2[bit_sel], p1[bit_sel], p0[bit_sel]};
   // step sequences the sub-cycles of each state; memory data returns one ce cycle after its address
   always_ff @(posedge clk) begin
      if (reset) begin
         state        <= IDLE;
         obj          <= '0;
         drawn        <= '0;
         step         <= '0;
         row          <= '0;
         code         <= '0;
         x            <= '0;
         p0           <= '0;
         p1           <= '0;
         p2           <= '0;
         api          <= 1'b0;
`ifdef MO_HFLIP_EN
         hflip        <= 1'b0;
`endif
         bus.mo_addr  <= '0;
         bus.gfx_addr <= '0;
         bus.buf_addr <= '0;
         bus.buf_ar   <= '0;
         bus.buf_api  <= 1'b0;
         bus.buf_we   <= 1'b0;
         bus.busy     <= 1'b0;
         bus.overflow <= 1'b0;
      end else if (bus.ce) begin
         bus.buf_we <= 1'b0;
         if (bus.line_start) begin
            state        <= SCAN;
            obj          <= '0;
            drawn        <= '0;
            step         <= '0;
            bus.busy     <= 1'b1;
            bus.overflow <= 1'b0;
         end else begin
            case (state)
               SCAN: begin
                  step <= step ^ 3'd1;
                  if (step == 3'd0) bus.mo_addr <= {6'(obj), 2'd0};
                  else if (diff < 8'(OBJ_H)) begin
                     if (drawn == DW'(MAX_PER_LINE)) begin
                        bus.overflow <= 1'b1;
                        bus.busy     <= 1'b0;
                        state        <= DONE;
                     end else begin
                        row   <= diff[3:0];
                        state <= ATTR;
                     end
                  end else if (last_obj) begin
                     bus.busy <= 1'b0;
                     state    <= DONE;
                  end else obj <= obj + 1'b1;
               end
               ATTR: begin
                  step <= step + 3'd1;
                  if (step != 3'd3) bus.mo_addr <= {6'(obj), step[1:0] + 2'd1};
                  if (step == 3'd1) code <= bus.mo_data;
                  if (step == 3'd2) begin
                     api <= bus.mo_data[7];
`ifdef MO_HFLIP_EN
                     hflip <= bus.mo_data[6];
`endif
                  end
                  if (step == 3'd3) begin
                     x     <= bus.mo_data;
                     step  <= '0;
                     state <= GFX;
                  end
               end
               GFX: begin
                  step <= step + 3'd1;
                  if (step != 3'd3) bus.gfx_addr <= {code, row, step[1:0]};
                  if (step == 3'd1) p0 <= bus.gfx_data;
                  if (step == 3'd2) p1 <= bus.gfx_data;
                  if (step == 3'd3) begin
                     p2    <= bus.gfx_data;
                     step  <= '0;
                     state <= DRAW;
                  end
               end
               DRAW: begin
                  step         <= step + 3'd1;
                  bus.buf_addr <= x + 8'(step);
                  bus.buf_ar   <= pix;
                  bus.buf_api  <= api;
                  bus.buf_we   <= |pix;
                  if (step == 3'd7) begin
                     drawn <= drawn + 1'b1;
                     if (last_obj) begin
                        bus.busy <= 1'b0;
                        state    <= DONE;
                     end else begin
                        obj   <= obj + 1'b1;
                        state <= SCAN;
                     end
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end
endmodule
